// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N-channel streaming multiplexer with valid/ready handshakes,
// a registered output stage and packet locking. A channel is chosen either by
// an external select or by a per-packet round-robin arbiter. Once a packet has
// started, its channel keeps the grant until the beat carrying in_last.
module mux_nto1_stream #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    output logic [SW-1:0]  out_chan,
    input  logic           out_ready
);

    localparam logic [SW:0] NL = (SW+1)'(N);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_t;

    lock_state_t   r_state, w_state_nxt;
    logic [SW-1:0] r_lock_chan, w_lock_chan_nxt;
    logic [SW-1:0] r_ptr, w_ptr_nxt;

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic          r_out_last;
    logic [SW-1:0] r_out_chan;

    logic          w_adv;
    logic          w_gnt_vld;
    logic [SW-1:0] w_gnt_idx;
    logic [W-1:0]  w_gnt_data;
    logic          w_gnt_last;
    logic          w_xfer;

    assign w_adv  = !r_out_valid || out_ready;
    assign w_xfer = w_adv && w_gnt_vld && in_valid[w_gnt_idx];

    // Grant selection: lock first, then external select or round-robin search.
    always_comb begin
        logic [SW:0] v_sum;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_sum     = '0;
        if (rst) begin
            w_gnt_vld = 1'b0;
        end else if (r_state == ST_LOCKED) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = r_lock_chan;
        end else if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SW'(i);
                end
            end
        end else begin
            // Walk offsets from far to near so the candidate closest to r_ptr wins.
            for (int unsigned k = N; k > 0; k--) begin
                v_sum = {1'b0, r_ptr} + (SW+1)'(k - 1);
                if (v_sum >= NL) begin
                    v_sum = v_sum - NL;
                end
                if (in_valid[v_sum[SW-1:0]]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = v_sum[SW-1:0];
                end
            end
        end
    end

    // Data/last mux and one-hot ready for the granted channel.
    always_comb begin
        w_gnt_data = '0;
        w_gnt_last = 1'b0;
        in_ready   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_gnt_idx == SW'(i)) begin
                w_gnt_data = in_data[i*W +: W];
                w_gnt_last = in_last[i];
                in_ready[i] = w_gnt_vld && w_adv;
            end
        end
    end

    // Lock / pointer next-state logic.
    always_comb begin
        logic [SW:0] v_inc;
        w_state_nxt     = r_state;
        w_lock_chan_nxt = r_lock_chan;
        w_ptr_nxt       = r_ptr;
        v_inc           = {1'b0, w_gnt_idx} + (SW+1)'(1);
        if (v_inc >= NL) begin
            v_inc = '0;
        end
        if (w_xfer) begin
            if (w_gnt_last) begin
                w_state_nxt = ST_OPEN;
                if (mode) begin
                    w_ptr_nxt = v_inc[SW-1:0];
                end
            end else begin
                w_state_nxt     = ST_LOCKED;
                w_lock_chan_nxt = w_gnt_idx;
            end
        end
    end

    // Lock state and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_OPEN;
            r_lock_chan <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_chan <= w_lock_chan_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    // Output register: refills whenever empty or being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_chan  <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_gnt_data;
                r_out_last <= w_gnt_last;
                r_out_chan <= w_gnt_idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_chan  = r_out_chan;

endmodule
